// File: rtl/acc_pkg.sv
// Shared constants and state type for the 16-bit stream accumulator.
package acc_pkg;
    localparam int ACC_W       = 16;
    localparam int CNT_W       = 8;
    localparam int NUM_OPS_DEF = 4;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_t;
endpackage

// File: rtl/RCA_16_bit.sv
// 16-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module RCA_16_bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);
    logic [16:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign carry_out = c[16];
endmodule

// File: rtl/acc_16_bit_seq.sv
// Frame accumulator: sums NUM_OPS operands through one RCA_16_bit in a feedback loop.
// Define ACC_SATURATE_EN to clamp the running total at 16'hFFFF instead of wrapping.
module acc_16_bit_seq
    import acc_pkg::*;
#(
    parameter int NUM_OPS = NUM_OPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_carry
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);

    acc_state_t       state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             cy, cy_n;

    logic [ACC_W-1:0] add_sum;
    logic             add_co;
    logic [ACC_W-1:0] acc_upd;

    RCA_16_bit u_rca (
        .x         (acc),
        .y         (in_data),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_co)
    );

`ifdef ACC_SATURATE_EN
    // Once saturated, any nonzero operand carries out again, so the clamp holds.
    assign acc_upd = add_co ? {ACC_W{1'b1}} : add_sum;
`else
    assign acc_upd = add_sum;
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        cy_n    = cy;
        if (clr) begin
            state_n = ACC;
            acc_n   = '0;
            cnt_n   = '0;
            cy_n    = 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        acc_n = acc_upd;
                        cy_n  = cy | add_co;
                        if (cnt == LAST) state_n = DONE;
                        else             cnt_n   = cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_n = ACC;
                        acc_n   = '0;
                        cnt_n   = '0;
                        cy_n    = 1'b0;
                    end
                end
                default: state_n = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            cy    <= cy_n;
        end
    end

    // Handshake flags come from the state register alone.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_carry = cy;
endmodule

// File: tb/tb_acc_16_bit_seq.sv
// Directed bench for acc_16_bit_seq: frame table plus backpressure, clr, reset, NUM_OPS=1 sequences.
module tb_acc_16_bit_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_carry;

    logic        v1 = 1'b0;
    logic        rdy1;
    logic [15:0] d1 = '0;
    logic        ov1;
    logic [15:0] s1;
    logic        c1;

    int checks = 0;
    int errors = 0;
    int in_hs1 = 0;
    int out_hs1 = 0;

    always #5 clk = ~clk;

    acc_16_bit_seq #(.NUM_OPS(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry)
    );

    acc_16_bit_seq #(.NUM_OPS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .out_valid(ov1), .out_ready(1'b1),
        .out_sum(s1), .out_carry(c1)
    );

    always @(posedge clk) begin
        if (rst_n && v1 && rdy1) in_hs1 <= in_hs1 + 1;
        if (rst_n && ov1)        out_hs1 <= out_hs1 + 1;
    end

    typedef struct {
        logic [3:0][15:0] d;
        logic [15:0]      sum;
        logic             carry;
    } vec_t;

    vec_t vec[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed4(input logic [3:0][15:0] d);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        vec[0].d = {16'd4, 16'd3, 16'd2, 16'd1};
        vec[0].sum = 16'd10; vec[0].carry = 1'b0;
        vec[1].d = {16'h0000, 16'h0000, 16'h0002, 16'hFFFF};
`ifdef ACC_SATURATE_EN
        vec[1].sum = 16'hFFFF;
`else
        vec[1].sum = 16'h0001;
`endif
        vec[1].carry = 1'b1;
        vec[2].d = {16'h0000, 16'h0000, 16'h8000, 16'h8000};
`ifdef ACC_SATURATE_EN
        vec[2].sum = 16'hFFFF;
`else
        vec[2].sum = 16'h0000;
`endif
        vec[2].carry = 1'b1;
        vec[3].d = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
        vec[3].sum = 16'hA000; vec[3].carry = 1'b0;
        vec[4].d = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`ifdef ACC_SATURATE_EN
        vec[4].sum = 16'hFFFF;
`else
        vec[4].sum = 16'hFFFC;
`endif
        vec[4].carry = 1'b1;

        // reset state
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_carry", out_carry, 0);
        step();
        rst_n = 1'b1;
        step();

        // table-driven frames, out_ready held high
        for (int i = 0; i < 5; i++) begin
            feed4(vec[i].d);
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_in_ready", i), in_ready, 0);
            chk($sformatf("v%0d_sum", i), out_sum, vec[i].sum);
            chk($sformatf("v%0d_carry", i), out_carry, vec[i].carry);
            step();
            chk($sformatf("v%0d_valid_drop", i), out_valid, 0);
            chk($sformatf("v%0d_ready_back", i), in_ready, 1);
            chk($sformatf("v%0d_cleared", i), {out_carry, out_sum}, 0);
        end

        // backpressure with a held operand
        out_ready = 1'b0;
        feed4({16'd1, 16'd1, 16'd1, 16'd1});
        in_valid = 1'b1;
        in_data  = 16'h0055;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", out_sum, 16'd4);
        end
        out_ready = 1'b1;
        step();
        chk("bp_handoff_ready", in_ready, 1);
        chk("bp_handoff_sum", out_sum, 0);
        step();
        in_valid = 1'b0;
        chk("bp_held_accepted", out_sum, 16'h0055);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0001;
            step();
        end
        in_valid = 1'b0;
        chk("bp_frame2_valid", out_valid, 1);
        chk("bp_frame2_sum", out_sum, 16'h0058);
        step();

        // clr mid-frame, coincident input ignored
        in_valid = 1'b1; in_data = 16'd7; step();
        in_data = 16'd9; step();
        chk("clr_partial", out_sum, 16'd16);
        clr = 1'b1; in_data = 16'd100; step();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_sum", out_sum, 0);
        chk("clr_ready", in_ready, 1);
        feed4({16'd1, 16'd1, 16'd1, 16'd1});
        chk("clr_frame_valid", out_valid, 1);
        chk("clr_frame_sum", out_sum, 16'd4);
        step();

        // clr discards a pending result
        out_ready = 1'b0;
        feed4({16'd2, 16'd2, 16'd2, 16'd2});
        chk("clr_done_valid", out_valid, 1);
        clr = 1'b1; out_ready = 1'b1; step();
        clr = 1'b0;
        chk("clr_done_drop", out_valid, 0);
        chk("clr_done_sum", out_sum, 0);

        // asynchronous reset between edges
        in_valid = 1'b1; in_data = 16'd5; step();
        step();
        in_valid = 1'b0;
        chk("arst_partial", out_sum, 16'd10);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", out_sum, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        feed4({16'd5, 16'd5, 16'd5, 16'd5});
        chk("arst_frame_valid", out_valid, 1);
        chk("arst_frame_sum", out_sum, 16'd20);
        step();

        // NUM_OPS=1 with random gaps
        for (int i = 0; i < 10; i++) begin
            logic [15:0] op;
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            op = 16'($urandom);
            v1 = 1'b1; d1 = op;
            step();
            v1 = 1'b0;
            chk("n1_valid", ov1, 1);
            chk("n1_sum", s1, op);
            chk("n1_carry", c1, 0);
            step();
            chk("n1_ready", rdy1, 1);
        end
        step();
        chk("n1_in_hs", in_hs1, 10);
        chk("n1_hs_match", out_hs1, in_hs1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
